dmem_responder: RTL and testbench

- Data-memory responder: the target end of the load/store request/response interface driven by the MEM stage of the 5-stage pipeline.
- Accepts one request at a time. Returns a read or write-ack after a fixed, parameterised latency. Flags misaligned and out-of-range accesses.
- Sits beside the pipeline top and lets the MEM stage be tested against variable memory latency.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, counter width,
// default MMIO address and the request address check.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_e;

   localparam int CNT_W = 4;
   localparam logic [31:0] DEF_MMIO_ADDR = 32'hFFFF_F000;

   // Addresses are widened to 64 bits so 4*MEM_WORDS can never overflow the compare.
   function automatic logic dmem_addr_err(
      input logic [63:0] addr,
      input logic [63:0] mem_bytes,
      input logic [63:0] mmio_addr,
      input logic        mmio_en
   );
      logic misaligned;
      logic in_mmio;
      logic out_of_range;
      misaligned   = (addr[1:0] != 2'b00);
      in_mmio      = mmio_en && (addr == mmio_addr);
      out_of_range = (addr >= mem_bytes) && !in_mmio;
      return misaligned || out_of_range;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module dmem_array #(
   parameter int DW    = 32,
   parameter int WORDS = 16384,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic            clk,
   input  logic            rd_en_i,
   input  logic [DW/8-1:0] we_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [DW-1:0]   wdata_i,
   output logic [DW-1:0]   rdata_o
);

   logic [DW-1:0] mem_q [WORDS];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      for (int b = 0; b < DW/8; b++) begin
         if (we_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
      if (rd_en_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed latency, error flagging.
// Optional MMIO output register enabled by defining DMEM_MMIO_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int               DBITS     = 32,
   parameter int               MEM_WORDS = 16384,
   parameter int               LATENCY   = 2,
   parameter logic [DBITS-1:0] MMIO_ADDR = DEF_MMIO_ADDR
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [DBITS-1:0] req_addr,
   input  logic [DBITS-1:0] req_wdata,
   input  logic [3:0]       req_be,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [DBITS-1:0] resp_rdata,
   output logic             resp_err,
   output logic [DBITS-1:0] mmio_out
);

   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd4;
`ifdef DMEM_MMIO_EN
   localparam logic MMIO_EN = 1'b1;
`else
   localparam logic MMIO_EN = 1'b0;
`endif

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be within 1..15");
   end

   dmem_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             req_ready_q, resp_valid_q, resp_err_q;
   logic             we_q, err_q, mmio_hit_q;
   logic [AW-1:0]    widx_q;
   logic             sel_mem_q, sel_mmio_q;

   logic             accept, req_err, req_mmio, rd_fire;
   logic [AW-1:0]    req_widx, ram_addr;
   logic [3:0]       ram_we;
   logic [DBITS-1:0] ram_rdata, mmio_val;

   assign accept   = req_valid && req_ready_q;
   assign req_err  = dmem_addr_err(64'(req_addr), MEM_BYTES, 64'(MMIO_ADDR), MMIO_EN);
   assign req_mmio = MMIO_EN && (req_addr == MMIO_ADDR);
   assign req_widx = req_addr[AW+1:2];

   // Stores commit at the accept edge; the only later array access is the load read.
   assign ram_we   = (accept && req_we && !req_err && !req_mmio) ? req_be : 4'b0000;
   assign rd_fire  = (state_q == ST_WAIT) && (cnt_q == '0) && !we_q && !err_q && !mmio_hit_q;
   assign ram_addr = (state_q == ST_IDLE) ? req_widx : widx_q;

   dmem_array #(
      .DW    (DBITS),
      .WORDS (MEM_WORDS),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .rd_en_i (rd_fire),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (req_wdata),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         mmio_hit_q   <= 1'b0;
         widx_q       <= '0;
         sel_mem_q    <= 1'b0;
         sel_mmio_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q     <= ST_WAIT;
                  req_ready_q <= 1'b0;
                  cnt_q       <= CNT_W'(LATENCY - 1);
                  we_q        <= req_we;
                  err_q       <= req_err;
                  mmio_hit_q  <= req_mmio;
                  widx_q      <= req_widx;
               end
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_q      <= ST_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= err_q;
                  sel_mem_q    <= rd_fire;
                  sel_mmio_q   <= !we_q && !err_q && mmio_hit_q;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state_q      <= ST_IDLE;
                  req_ready_q  <= 1'b1;
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  sel_mem_q    <= 1'b0;
                  sel_mmio_q   <= 1'b0;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               req_ready_q  <= 1'b1;
               resp_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef DMEM_MMIO_EN
   logic [DBITS-1:0] mmio_q, mmio_d;
   logic             mmio_wr;

   assign mmio_wr = accept && req_we && req_mmio && !req_err;

   for (genvar gi = 0; gi < 4; gi++) begin : g_mmio_byte
      assign mmio_d[gi*8 +: 8] = (mmio_wr && req_be[gi]) ? req_wdata[gi*8 +: 8]
                                                         : mmio_q[gi*8 +: 8];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mmio_q <= '0;
      end else begin
         mmio_q <= mmio_d;
      end
   end

   assign mmio_val = mmio_q;
`else
   assign mmio_val = '0;
`endif

   // The RAM read register only loads on the edge entering RESP, so it holds under backpressure.
   assign resp_rdata = sel_mem_q  ? ram_rdata :
                       sel_mmio_q ? mmio_val  : '0;
   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign mmio_out   = mmio_val;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY = 2, MEM_WORDS = 16384).
module tb_dmem_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata, mmio_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_responder #(
      .DBITS     (32),
      .MEM_WORDS (16384),
      .LATENCY   (LAT),
      .MMIO_ADDR (32'hFFFF_F000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mmio_out   (mmio_out)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One full transaction; hold = cycles of resp_ready low once the response is up.
   task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold,
                      input logic [31:0] exp_rdata, input logic exp_err);
      int n;
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      req_be     = be;
      resp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq({tag, "_lat"}, 32'(n), 32'(LAT));
      check_eq({tag, "_rdata"}, resp_rdata, exp_rdata);
      check_eq({tag, "_err"}, 32'(resp_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_eq({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
         check_eq({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
         check_eq({tag, "_hold_err"}, 32'(resp_err), 32'(exp_err));
         check_eq({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check_eq({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
      check_eq({tag, "_done_rdy"}, 32'(req_ready), 32'd1);
      $display("txn %s we=%0d addr=0x%08h wdata=0x%08h be=%b -> rdata=0x%08h err=%0d",
               tag, we, addr, wdata, be, exp_rdata, exp_err);
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_be     = '0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_req_ready", 32'(req_ready), 32'd1);
      check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_eq("rst_resp_rdata", resp_rdata, 32'd0);
      check_eq("rst_resp_err", 32'(resp_err), 32'd0);
      check_eq("rst_mmio_out", mmio_out, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      txn("st_full",  1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0);
      txn("ld_full",  1'b0, 32'h10, 32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0);
      txn("st_byte0", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, 32'h0,     1'b0);
      txn("ld_byte0", 1'b0, 32'h10, 32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0);

      txn("ld_misal", 1'b0, 32'h13,        32'h0, 4'h0, 0, 32'h0, 1'b1);
      txn("ld_oor",   1'b0, 32'h0001_0000, 32'h0, 4'h0, 0, 32'h0, 1'b1);
      txn("st_word0", 1'b1, 32'h0,         32'h11111111, 4'hF, 0, 32'h0, 1'b0);
      txn("st_oor",   1'b1, 32'h0001_0000, 32'h22222222, 4'hF, 0, 32'h0, 1'b1);
      txn("st_misal", 1'b1, 32'h11,        32'h33333333, 4'hF, 0, 32'h0, 1'b1);
      txn("ld_word0", 1'b0, 32'h0,         32'h0, 4'h0, 0, 32'h11111111, 1'b0);
      txn("ld_chk10", 1'b0, 32'h10,        32'h0, 4'h0, 0, 32'hDEADBEAA, 1'b0);

      txn("st_be0",   1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0);
      txn("ld_be0",   1'b0, 32'h10,   32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0);
      txn("st_last",  1'b1, 32'hFFFC, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0);
      txn("ld_last",  1'b0, 32'hFFFC, 32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0);
      txn("st_hi2",   1'b1, 32'h10,   32'h5A5A0000, 4'b1100, 0, 32'h0, 1'b0);

      txn("ld_bp",    1'b0, 32'h10,   32'h0,        4'h0, 5, 32'h5A5ABEAA, 1'b0);
      txn("ld_after_bp", 1'b0, 32'hFFFC, 32'h0,     4'h0, 0, 32'hCAFEF00D, 1'b0);

      // Reset lands while a load is waiting out its latency.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h10;
      req_be    = 4'h0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_eq("rst_mid_inwait", 32'(req_ready), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_eq("rst_mid_valid", 32'(resp_valid), 32'd0);
      check_eq("rst_mid_ready", 32'(req_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_mid_quiet", 32'(resp_valid), 32'd0);
      $display("txn rst_mid load addr=0x00000010 abandoned by reset");
      txn("ld_post_rst", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'h5A5ABEAA, 1'b0);

`ifdef DMEM_MMIO_EN
      txn("mmio_st", 1'b1, 32'hFFFF_F000, 32'h12345678, 4'hF, 0, 32'h0, 1'b0);
      check_eq("mmio_out_st", mmio_out, 32'h12345678);
      txn("mmio_ld", 1'b0, 32'hFFFF_F000, 32'h0, 4'h0, 0, 32'h12345678, 1'b0);
      txn("mmio_b1", 1'b1, 32'hFFFF_F000, 32'h0000EE00, 4'b0010, 0, 32'h0, 1'b0);
      check_eq("mmio_out_b1", mmio_out, 32'h1234EE78);
`else
      txn("mmio_st", 1'b1, 32'hFFFF_F000, 32'h12345678, 4'hF, 0, 32'h0, 1'b1);
      check_eq("mmio_out_st", mmio_out, 32'h0);
      txn("mmio_ld", 1'b0, 32'hFFFF_F000, 32'h0, 4'h0, 0, 32'h0, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
